// File: rtl/blinky_pkg.sv
// rtl/blinky_pkg.sv - shared mode encoding for the blinky DDR pattern generator
// Purpose: display-mode enum, mode count and the mode-step helper.
// Ports: none (package).
package blinky_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SHIFT = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_DDR   = 2'd3
    } mode_e;

    localparam int MODE_NR = 4;

    // Four modes fill the 2-bit encoding exactly, so the increment wraps DDR back to COUNT.
    function automatic mode_e next_mode(input mode_e m);
        logic [1:0] n;
        n = m + 2'd1;
        return mode_e'(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key synchroniser, debouncer and press-pulse generator
// Purpose: turns a raw asynchronous button into a single-cycle press pulse.
// Ports:
//   clk     in  system clock
//   rst_i   in  synchronous reset, active-low
//   key_i   in  raw button level, asynchronous to clk
//   press_o out one-cycle pulse on each debounced press
module key_debounce #(
    parameter int DEB_W   = 16,
    parameter bit INV_BTN = 1'b1
) (
    input  logic clk,
    input  logic rst_i,
    input  logic key_i,
    output logic press_o
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       vld_q, vld_d;
    logic             armed_q, armed_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             press_q, press_d;

    always_comb begin
        sync1_d = key_i ^ INV_BTN;
        sync2_d = sync1_q;
        // vld_q[1] marks that sync2_q holds a real post-reset sample of the pin.
        vld_d   = {vld_q[0], 1'b1};
        // Presses are only honoured once the key has been seen released after reset,
        // so a key held through reset cannot fire until it is let go and pressed again.
        armed_d = armed_q | (vld_q[1] & ~sync2_q);
        cnt_d   = '0;
        deb_d   = deb_q;
        if (sync2_q != deb_q) begin
            if (&cnt_q) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = armed_q & deb_d & ~deb_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld_q   <= 2'b00;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            vld_q   <= vld_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/blinky_ddr_gen.sv
// rtl/blinky_ddr_gen.sv - multi-channel LED pattern generator with ODDR D0/D1 outputs
// Purpose: free-running counter drives four key-selectable LED patterns.
// Ports:
//   clk      in  system clock
//   rst_i    in  synchronous reset, active-low
//   key_i    in  raw mode-step button
//   run_i    in  1 = counter advances, 0 = patterns freeze
//   led_o    out direct LED levels
//   ddr_d0_o out ODDR D0 per channel
//   ddr_d1_o out ODDR D1 per channel
//   mode_o   out current display mode
module blinky_ddr_gen
    import blinky_pkg::*;
#(
    parameter int LEDS_NR = 6,
    parameter int CTR_W   = 25,
    parameter int TICK_W  = 20,
    parameter int PWM_W   = 8,
    parameter int DEB_W   = 16,
    parameter bit INV_BTN = 1'b1,
    parameter bit INV_LED = 1'b1
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               key_i,
    input  logic               run_i,
    output logic [LEDS_NR-1:0] led_o,
    output logic [LEDS_NR-1:0] ddr_d0_o,
    output logic [LEDS_NR-1:0] ddr_d1_o,
    output logic [1:0]         mode_o
);

    localparam logic [LEDS_NR-1:0] OUT_OFF  = {LEDS_NR{INV_LED}};
    localparam logic [LEDS_NR-1:0] SHIFT_RST = {{(LEDS_NR-1){1'b0}}, 1'b1};

    logic               press;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    mode_e              mode_q, mode_d;
    logic [LEDS_NR-1:0] shift_q, shift_d;
    logic [LEDS_NR-1:0] led_q, led_d;
    logic [LEDS_NR-1:0] d0_q, d0_d;
    logic [LEDS_NR-1:0] d1_q, d1_d;
    logic [LEDS_NR-1:0] lvl;
    logic               tick;
    logic [PWM_W:0]     tri_v;
    logic [PWM_W-1:0]   duty;

    key_debounce #(
        .DEB_W  (DEB_W),
        .INV_BTN(INV_BTN)
    ) u_key (
        .clk    (clk),
        .rst_i  (rst_i),
        .key_i  (key_i),
        .press_o(press)
    );

    always_comb begin
        ctr_d  = run_i ? ctr_q + 1'b1 : ctr_q;
        tick   = run_i & (&ctr_q[TICK_W-1:0]);
        mode_d = press ? next_mode(mode_q) : mode_q;

        // Reload on SHIFT entry takes priority over a coincident tick.
        shift_d = shift_q;
        if (press && (mode_d == MODE_SHIFT)) begin
            shift_d = SHIFT_RST;
        end else if (tick) begin
            shift_d = {shift_q[LEDS_NR-2:0], shift_q[LEDS_NR-1]};
        end

        // Triangle duty: ramp up on the first half of the PWM_W+1 bit window, down on the second.
        // The size cast reads bits above the counter as zero when the window overruns CTR_W.
        tri_v = (PWM_W+1)'(ctr_q >> TICK_W);
        duty  = tri_v[PWM_W] ? ~tri_v[PWM_W-1:0] : tri_v[PWM_W-1:0];

        lvl = '0;
        case (mode_q)
            MODE_COUNT: begin
                for (int i = 0; i < LEDS_NR; i++) begin
                    lvl[i] = ctr_q[CTR_W-LEDS_NR+i];
                end
            end
            MODE_SHIFT: lvl = shift_q;
            MODE_PWM:   lvl = {LEDS_NR{ctr_q[PWM_W-1:0] < duty}};
            MODE_DDR: begin
                for (int i = 0; i < LEDS_NR; i++) begin
                    lvl[i] = ctr_q[CTR_W-1-i];
                end
            end
            default: lvl = '0;
        endcase

        led_d = lvl ^ OUT_OFF;
        d1_d  = led_d;
        // In DDR mode D0 is held off so the pin toggles at clk rate whenever lvl is high.
        d0_d  = (mode_q == MODE_DDR) ? OUT_OFF : led_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_i) begin
            ctr_q   <= '0;
            mode_q  <= MODE_COUNT;
            shift_q <= SHIFT_RST;
            led_q   <= OUT_OFF;
            d0_q    <= OUT_OFF;
            d1_q    <= OUT_OFF;
        end else begin
            ctr_q   <= ctr_d;
            mode_q  <= mode_d;
            shift_q <= shift_d;
            led_q   <= led_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
        end
    end

    assign led_o    = led_q;
    assign ddr_d0_o = d0_q;
    assign ddr_d1_o = d1_q;
    assign mode_o   = mode_q;

endmodule
